core_ifetch: RTL and testbench
==============================

// Module: core_ifetch
// PURPOSE
//  Instruction fetch stage. Owns the PC, issues in-order word fetches to
//  instruction memory, buffers returned instructions with their PC, and
//  delivers them to decode over a valid/ready handshake. Consumes
//  core_alu's o_branch_jalr/o_branch_jalr_target (and decode's JAL) as
//  a redirect that flushes the buffer and all in-flight fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset
//  BUF_DEPTH  2              instruction buffer entries (power of 2, >=2)
// PORTS
//  i_clk              in   1   clock, all state on rising edge
//  i_rstn             in   1   asynchronous active-low reset
//  i_redirect         in   1   taken branch/JAL/JALR this cycle
//  i_redirect_target  in   32  new PC; bits [1:0] are forced to 0
//  o_imem_req         out  1   fetch request valid
//  o_imem_addr        out  32  fetch word address
//  i_imem_gnt         in   1   request accepted this cycle
//  i_imem_rvalid      in   1   read data valid (in order, >=1 cycle after gnt)
//  i_imem_rdata       in   32  instruction word
//  o_valid            out  1   instruction available to decode
//  i_ready            in   1   decode accepts instruction
//  o_pc               out  32  PC of head instruction
//  o_instr            out  32  head instruction
// BEHAVIOUR
//  State: fetch_pc, resp_pc, outstanding (in-flight accepted reqs),
//   discard_cnt, buffer {pc,instr} x BUF_DEPTH with count, req_en flop.
//  Reset: fetch_pc=resp_pc=RESET_PC; outstanding=discard_cnt=count=0;
//   req_en=0 -> o_imem_req=0, o_valid=0, o_pc=o_instr=0 (empty buffer
//   drives zeros). req_en sets on first clock after i_rstn rises.
//  Issue: o_imem_req = req_en & !i_redirect &
//   (outstanding + count < BUF_DEPTH); o_imem_addr = fetch_pc.
//   On req&gnt: fetch_pc += 4, outstanding++. While req is held without
//   gnt, addr is stable; only a redirect may withdraw it.
//  Response: on rvalid, outstanding--. If discard_cnt!=0: drop data,
//   discard_cnt--. Else push {resp_pc, rdata}, resp_pc += 4. The issue
//   limit guarantees a push never finds the buffer full; rvalid with
//   outstanding==0 is a protocol error (assertion).
//  Delivery: o_valid = (count!=0); o_pc/o_instr = head entry. Pop when
//   o_valid & i_ready & !i_redirect. rvalid->o_valid latency 1 cycle
//   (no bypass). Push and pop in same cycle: count unchanged.
//  Redirect (i_redirect=1, wins over everything): buffer emptied
//   (count=0, no pop counted), fetch_pc=resp_pc=target&~3, no request
//   issued this cycle, discard_cnt = outstanding - i_imem_rvalid (all
//   still-in-flight responses dropped, including earlier-marked ones).
//   First new request appears the next cycle. Back-to-back redirects:
//   last target wins.
//  Arithmetic: PC adds are 32-bit, wrap 32'hFFFF_FFFC -> 0 silently.
//  Reset mid-operation clears all state immediately; imem shares i_rstn
//   so no stale responses arrive after reset.
// TESTING
//  1 Reset release, gnt=1, 1-cycle rvalid, ready=1 -> addrs 0,4,8...;
//    o_pc/o_instr match each word, one instr/cycle sustained.
//  2 ready=0 -> at most BUF_DEPTH reqs outstanding+buffered, req drops;
//    ready=1 resumes with no loss/duplication, order preserved.
//  3 Redirect to 0x0000_0103 with 2 in flight -> both responses dropped,
//    next o_pc=0x0000_0100, o_valid low in redirect cycle.
//  4 Redirect coincident with rvalid and i_ready -> that word not
//    delivered or buffered, discard_cnt=outstanding-1, no pop counted.
//  5 fetch_pc=0xFFFF_FFFC -> next addr 0x0000_0000; gnt held low 5
//    cycles -> addr stable, no pc advance.
//  6 i_rstn low mid-stream -> outputs zero asynchronously; restart at
//    RESET_PC one cycle after release.

Source files
------------

// File: rtl/core_ifetch_if.sv
// rtl/core_ifetch_if.sv - fetch stage redirect, imem and decode signal bundle
interface core_ifetch_if;
  logic        i_redirect;
  logic [31:0] i_redirect_target;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [31:0] o_instr;

  // fetch stage side
  modport master (
    input  i_redirect, i_redirect_target, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_ready,
    output o_imem_req, o_imem_addr, o_valid, o_pc, o_instr
  );

  // memory / decode / branch side
  modport slave (
    output i_redirect, i_redirect_target, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_ready,
    input  o_imem_req, o_imem_addr, o_valid, o_pc, o_instr
  );
endinterface

// File: rtl/core_ifetch.sv
// rtl/core_ifetch.sv - instruction fetch: PC, in-order imem requests, instruction buffer, redirect flush
module core_ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic           i_clk,
  input logic           i_rstn,
  core_ifetch_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          req_en;
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [31:0]   buf_instr [BUF_DEPTH];

  logic [SW-1:0] occupancy;
  logic          req;
  logic          issue;
  logic          drop;
  logic          push;
  logic          pop;
  logic          valid;
  logic [31:0]   target_aligned;

  // Handshake decode; in-flight plus buffered words never exceed the buffer,
  // so a returning word always has a free slot.
  always_comb begin
    occupancy      = SW'(outstanding) + SW'(count);
    valid          = (count != '0);
    req            = req_en & ~bus.i_redirect & (occupancy < SW'(BUF_DEPTH));
    issue          = req & bus.i_imem_gnt;
    drop           = bus.i_imem_rvalid & (discard_cnt != '0);
    push           = bus.i_imem_rvalid & (discard_cnt == '0) & ~bus.i_redirect;
    pop            = valid & bus.i_ready & ~bus.i_redirect;
    target_aligned = bus.i_redirect_target & ~32'h3;
  end

  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = fetch_pc;
  assign bus.o_valid     = valid;
  assign bus.o_pc        = valid ? buf_pc[head] : 32'h0;
  assign bus.o_instr     = valid ? buf_instr[head] : 32'h0;

  // PC, counters and buffer pointers; redirect overrides every other update
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      req_en      <= 1'b0;
    end else begin
      req_en <= 1'b1;
      if (bus.i_redirect) begin
        fetch_pc    <= target_aligned;
        resp_pc     <= target_aligned;
        outstanding <= outstanding - CW'(bus.i_imem_rvalid);
        discard_cnt <= outstanding - CW'(bus.i_imem_rvalid);
        count       <= '0;
        head        <= '0;
        tail        <= '0;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        outstanding <= outstanding + CW'(issue) - CW'(bus.i_imem_rvalid);
        if (drop) begin
          discard_cnt <= discard_cnt - 1'b1;
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          tail    <= tail + 1'b1;
        end
        if (pop) begin
          head <= head + 1'b1;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Buffer storage; stale entries are never visible because outputs are gated by count
  always_ff @(posedge i_clk) begin
    if (push) begin
      buf_pc[tail]    <= resp_pc;
      buf_instr[tail] <= bus.i_imem_rdata;
    end
  end

  // Memory must never return data that was not requested
  rvalid_has_request: assert property (
    @(posedge i_clk) disable iff (!i_rstn) bus.i_imem_rvalid |-> (outstanding != '0)
  );
endmodule

// File: tb/tb_core_ifetch.sv
// tb/tb_core_ifetch.sv - directed self-checking bench for core_ifetch
module tb_core_ifetch;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  core_ifetch_if bus();

  core_ifetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(4)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;
  int lat = 1;
  int ndeliv;
  logic gnt_on, drv_ready, drv_redirect, found;
  logic [31:0] drv_target, exp_pc;
  logic [31:0] pend_addr[$];
  int pend_due[$];
  logic obs_req, obs_valid, obs_fire;
  logic [31:0] obs_addr, obs_pc, obs_instr, dummy_a;
  int dummy_d;

  // One clock cycle: drive inputs at negedge, act as imem, sample outputs 1ns later
  task automatic cyc();
    int due;
    @(negedge clk);
    bus.i_imem_gnt = gnt_on;
    bus.i_ready = drv_ready;
    bus.i_redirect = drv_redirect;
    bus.i_redirect_target = drv_target;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc_no) begin
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata = ~pend_addr[0];
      dummy_a = pend_addr.pop_front();
      dummy_d = pend_due.pop_front();
    end else begin
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata = 32'h0;
    end
    #1;
    obs_req = bus.o_imem_req;
    obs_addr = bus.o_imem_addr;
    obs_valid = bus.o_valid;
    obs_pc = bus.o_pc;
    obs_instr = bus.o_instr;
    obs_fire = obs_valid & drv_ready & ~drv_redirect;
    if (obs_req && gnt_on) begin
      due = cyc_no + lat;
      if (pend_due.size() != 0 && due <= pend_due[$]) due = pend_due[$] + 1;
      pend_addr.push_back(obs_addr);
      pend_due.push_back(due);
    end
    cyc_no++;
  endtask

  task automatic test_reset();
    gnt_on = 0; drv_ready = 0; drv_redirect = 0; drv_target = 0; lat = 1;
    bus.i_imem_gnt = 0; bus.i_ready = 0; bus.i_redirect = 0; bus.i_redirect_target = 0;
    bus.i_imem_rvalid = 0; bus.i_imem_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.o_imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", bus.o_imem_req); end
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
    checks++; if (bus.o_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", bus.o_pc); end
    checks++; if (bus.o_instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 0", bus.o_instr); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++; if (bus.o_imem_req !== 1'b0) begin failures++; $display("FAIL release_req: got %b expected 0", bus.o_imem_req); end
    cyc();
    checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin failures++; $display("FAIL first_req: got req=%b addr=%h expected 1/00000000", obs_req, obs_addr); end
  endtask

  task automatic test_stream();
    gnt_on = 1; drv_ready = 1; lat = 1; exp_pc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      checks++; if (obs_req !== 1'b1 || obs_addr !== 32'(4 * i)) begin failures++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h expected 1/%h", i, obs_req, obs_addr, 32'(4 * i)); end
      if (i < 2) begin
        checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_early[%0d]: got %b expected 0", i, obs_valid); end
      end else begin
        checks++; if (obs_valid !== 1'b1 || obs_pc !== exp_pc || obs_instr !== ~exp_pc) begin failures++; $display("FAIL stream_word[%0d]: got v=%b pc=%h instr=%h expected 1/%h/%h", i, obs_valid, obs_pc, obs_instr, exp_pc, ~exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic test_backpressure();
    drv_ready = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (obs_valid !== 1'b1 || obs_pc !== exp_pc) begin failures++; $display("FAIL bp_head[%0d]: got v=%b pc=%h expected 1/%h", i, obs_valid, obs_pc, exp_pc); end
      if (i >= 2) begin
        checks++; if (obs_req !== 1'b0) begin failures++; $display("FAIL bp_req_drop[%0d]: got %b expected 0", i, obs_req); end
      end
    end
    drv_ready = 1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++; if (obs_valid !== 1'b1 || obs_pc !== exp_pc || obs_instr !== ~exp_pc) begin failures++; $display("FAIL bp_resume[%0d]: got v=%b pc=%h instr=%h expected 1/%h/%h", i, obs_valid, obs_pc, obs_instr, exp_pc, ~exp_pc); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect();
    gnt_on = 0; drv_ready = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (obs_fire) begin
        checks++; if (obs_pc !== exp_pc) begin failures++; $display("FAIL drain_pc: got %h expected %h", obs_pc, exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end
    end
    gnt_on = 1; lat = 3;
    repeat (2) cyc();
    drv_redirect = 1; drv_target = 32'h0000_0103;
    cyc();
    checks++; if (obs_req !== 1'b0) begin failures++; $display("FAIL redir_req: got %b expected 0", obs_req); end
    drv_redirect = 0;
    exp_pc = 32'h0000_0100; ndeliv = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i == 0) begin
        checks++; if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h0000_0100) begin failures++; $display("FAIL redir_next: got v=%b req=%b addr=%h expected 0/1/00000100", obs_valid, obs_req, obs_addr); end
      end
      if (obs_fire) begin
        checks++; if (obs_pc !== exp_pc || obs_instr !== ~exp_pc) begin failures++; $display("FAIL redir_word: got pc=%h instr=%h expected %h/%h", obs_pc, obs_instr, exp_pc, ~exp_pc); end
        exp_pc = exp_pc + 32'd4; ndeliv++;
      end
    end
    checks++; if (ndeliv < 1) begin failures++; $display("FAIL redir_deliveries: got %0d expected >=1", ndeliv); end
  endtask

  task automatic test_redirect_rvalid();
    lat = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (obs_fire) begin
        checks++; if (obs_pc !== exp_pc) begin failures++; $display("FAIL rv_pre_pc: got %h expected %h", obs_pc, exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end
    end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (pend_due.size() != 0 && pend_due[0] <= cyc_no) found = 1;
      else cyc();
    end
    checks++; if (!found) begin failures++; $display("FAIL rv_setup: got no pending response expected one"); end
    drv_redirect = 1; drv_target = 32'h0000_0200;
    cyc();
    checks++; if (obs_req !== 1'b0) begin failures++; $display("FAIL rv_redir_req: got %b expected 0", obs_req); end
    drv_redirect = 0;
    cyc();
    checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL rv_not_buffered: got %b expected 0", obs_valid); end
    exp_pc = 32'h0000_0200; ndeliv = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (obs_fire) begin
        checks++; if (obs_pc !== exp_pc || obs_instr !== ~exp_pc) begin failures++; $display("FAIL rv_word: got pc=%h instr=%h expected %h/%h", obs_pc, obs_instr, exp_pc, ~exp_pc); end
        exp_pc = exp_pc + 32'd4; ndeliv++;
      end
    end
    checks++; if (ndeliv < 3) begin failures++; $display("FAIL rv_deliveries: got %0d expected >=3", ndeliv); end
  endtask

  task automatic test_wrap_stall();
    gnt_on = 0;
    drv_redirect = 1; drv_target = 32'hFFFF_FFFC;
    cyc();
    drv_redirect = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC || obs_valid !== 1'b0) begin failures++; $display("FAIL stall_addr[%0d]: got req=%b addr=%h v=%b expected 1/fffffffc/0", i, obs_req, obs_addr, obs_valid); end
    end
    gnt_on = 1;
    cyc();
    checks++; if (obs_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_last: got %h expected fffffffc", obs_addr); end
    cyc();
    checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr: got req=%b addr=%h expected 1/00000000", obs_req, obs_addr); end
    exp_pc = 32'hFFFF_FFFC; ndeliv = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (obs_fire) begin
        checks++; if (obs_pc !== exp_pc || obs_instr !== ~exp_pc) begin failures++; $display("FAIL wrap_word: got pc=%h instr=%h expected %h/%h", obs_pc, obs_instr, exp_pc, ~exp_pc); end
        exp_pc = exp_pc + 32'd4; ndeliv++;
      end
    end
    checks++; if (ndeliv < 3) begin failures++; $display("FAIL wrap_deliveries: got %0d expected >=3", ndeliv); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (bus.o_imem_req !== 1'b0 || bus.o_valid !== 1'b0) begin failures++; $display("FAIL midrst_ctrl: got req=%b v=%b expected 0/0", bus.o_imem_req, bus.o_valid); end
    checks++; if (bus.o_pc !== 32'h0 || bus.o_instr !== 32'h0) begin failures++; $display("FAIL midrst_data: got pc=%h instr=%h expected 0/0", bus.o_pc, bus.o_instr); end
    pend_addr.delete(); pend_due.delete();
    bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++; if (bus.o_imem_req !== 1'b0) begin failures++; $display("FAIL midrst_release_req: got %b expected 0", bus.o_imem_req); end
    gnt_on = 1; drv_ready = 1; lat = 1;
    cyc();
    checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin failures++; $display("FAIL midrst_restart: got req=%b addr=%h expected 1/00000000", obs_req, obs_addr); end
    exp_pc = 32'h0; ndeliv = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (obs_fire) begin
        checks++; if (obs_pc !== exp_pc || obs_instr !== ~exp_pc) begin failures++; $display("FAIL midrst_word: got pc=%h instr=%h expected %h/%h", obs_pc, obs_instr, exp_pc, ~exp_pc); end
        exp_pc = exp_pc + 32'd4; ndeliv++;
      end
    end
    checks++; if (ndeliv < 3) begin failures++; $display("FAIL midrst_deliveries: got %0d expected >=3", ndeliv); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_rvalid();
    test_wrap_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
